// File: rtl/sensor_window_stats.sv
// sensor_window_stats: circular sample history with windowed avg/min/max.
// Each accepted sample triggers a sequential newest-first scan of the last
// n = min(duration, count, DEPTH) entries, followed by a restoring divide.
// The history is written only while idle and read only while scanning, so
// it can map to a single-port RAM.
module sensor_window_stats #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 200,
  parameter int CNT_W  = 8,
  parameter int SUM_W  = DATA_W + CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [CNT_W-1:0]  duration,
  output logic              sample_dropped,
  output logic [DATA_W-1:0] latest_sample,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              avg_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DC_W  = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, n_q, left_q;
  logic [DATA_W-1:0]   latest_q, avg_q, min_q, max_q, mn_q, mx_q;
  logic                avg_valid_q, dropped_q;
  logic [SUM_W-1:0]    quo_q, rem_q;   // quo_q doubles as the accumulator
  logic [DC_W-1:0]     div_cnt_q;

  logic                accept;
  logic [CNT_W-1:0]    cnt_inc, n_new;
  logic [DATA_W-1:0]   rd_data;
  logic [SUM_W:0]      rem_sh, div_ext;
  logic                ge;

  assign accept  = sample_valid && (state_q == S_IDLE);
  assign cnt_inc = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
  // cnt_inc never exceeds DEPTH, so this also clamps duration to DEPTH
  assign n_new   = (duration < cnt_inc) ? duration : cnt_inc;
  assign rd_data = buf_q[rd_ptr_q];

  // One restoring-divide step: shift next dividend bit into the remainder
  assign rem_sh  = {rem_q, quo_q[SUM_W-1]};
  assign div_ext = {{(SUM_W+1-CNT_W){1'b0}}, n_q};
  assign ge      = (rem_sh >= div_ext);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: an empty window skips straight to the result step
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (n_new == '0) ? S_DONE : S_SUM;
      S_SUM:  if (left_q == CNT_W'(1)) state_d = S_DIV;
      S_DIV:  if (div_cnt_q == DC_W'(SUM_W - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // History storage, no reset: count masks stale entries
  always_ff @(posedge clock) begin
    if (accept) buf_q[wr_ptr_q] <= sample;
  end

  // Datapath: acceptance bookkeeping, window scan, divide, result capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      n_q         <= '0;
      left_q      <= '0;
      latest_q    <= '0;
      avg_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      mn_q        <= '0;
      mx_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
      avg_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      dropped_q   <= sample_valid && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: if (accept) begin
          wr_ptr_q  <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
          count_q   <= cnt_inc;
          latest_q  <= sample;
          n_q       <= n_new;
          left_q    <= n_new;
          rd_ptr_q  <= wr_ptr_q;  // newest entry is the one written now
          quo_q     <= '0;
          rem_q     <= '0;
          mn_q      <= '1;
          mx_q      <= '0;
          div_cnt_q <= '0;
        end
        S_SUM: begin
          quo_q    <= quo_q + SUM_W'(rd_data);
          if (rd_data < mn_q) mn_q <= rd_data;
          if (rd_data > mx_q) mx_q <= rd_data;
          rd_ptr_q <= (rd_ptr_q == '0) ? PTR_W'(DEPTH - 1) : rd_ptr_q - PTR_W'(1);
          left_q   <= left_q - CNT_W'(1);
        end
        S_DIV: begin
          rem_q     <= ge ? SUM_W'(rem_sh - div_ext) : rem_sh[SUM_W-1:0];
          quo_q     <= {quo_q[SUM_W-2:0], ge};
          div_cnt_q <= div_cnt_q + DC_W'(1);
        end
        S_DONE: begin
          // quotient never exceeds the window max, so low bits suffice
          avg_q       <= (n_q == '0) ? '0 : quo_q[DATA_W-1:0];
          min_q       <= (n_q == '0) ? '0 : mn_q;
          max_q       <= (n_q == '0) ? '0 : mx_q;
          avg_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sample_ready   = (state_q == S_IDLE);
  assign sample_dropped = dropped_q;
  assign latest_sample  = latest_q;
  assign count          = count_q;
  assign avg_out        = avg_q;
  assign min_out        = min_q;
  assign max_out        = max_q;
  assign avg_valid      = avg_valid_q;

endmodule

// File: tb/tb_sensor_window_stats.sv
// Directed bench for sensor_window_stats with DATA_W=8, DEPTH=8, CNT_W=4.
module tb_sensor_window_stats;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [3:0] duration = '0;
  logic       sample_dropped;
  logic [7:0] latest_sample;
  logic [3:0] count;
  logic [7:0] avg_out, min_out, max_out;
  logic       avg_valid;

  int checks = 0;
  int errors = 0;

  sensor_window_stats #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .duration(duration), .sample_dropped(sample_dropped),
    .latest_sample(latest_sample), .count(count), .avg_out(avg_out),
    .min_out(min_out), .max_out(max_out), .avg_valid(avg_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Count edges until avg_valid, starting from edge number 'start'
  task automatic wait_avg(input int start, output int lat, output logic rdy_between);
    lat = start;
    rdy_between = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      lat++;
      if (avg_valid) return;
      if (sample_ready) rdy_between = 1'b1;
    end
    lat = -1;
  endtask

  task automatic send(input logic [7:0] s, input logic [3:0] d, output int lat,
                      output logic rdy_between);
    @(negedge clock);
    sample = s;
    duration = d;
    sample_valid = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    wait_avg(0, lat, rdy_between);
  endtask

  initial begin
    int   lat;
    logic rdy;
    logic seen;

    // Reset state
    do_reset();
    @(negedge clock);
    chk("rst_ready", sample_ready, 1);
    chk("rst_avg", avg_out, 0);
    chk("rst_min", min_out, 0);
    chk("rst_max", max_out, 0);
    chk("rst_latest", latest_sample, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_dropped", sample_dropped, 0);

    // 1: single sample, n=1
    send(8'd10, 4'd4, lat, rdy);
    chk("t1_lat", lat, 14);
    chk("t1_ready_between", rdy, 0);
    chk("t1_ready_at_valid", sample_ready, 1);
    chk("t1_avg", avg_out, 10);
    chk("t1_min", min_out, 10);
    chk("t1_max", max_out, 10);
    chk("t1_latest", latest_sample, 10);
    chk("t1_count", count, 1);
    @(posedge clock); #1;
    chk("t1_valid_pulse", avg_valid, 0);
    chk("t1_avg_hold", avg_out, 10);

    // 2: growing window 10,20,30,40
    do_reset();
    send(8'd10, 4'd4, lat, rdy);
    chk("t2_lat1", lat, 14);
    send(8'd20, 4'd4, lat, rdy);
    chk("t2_lat2", lat, 15);
    chk("t2_avg2", avg_out, 15);
    send(8'd30, 4'd4, lat, rdy);
    chk("t2_lat3", lat, 16);
    send(8'd40, 4'd4, lat, rdy);
    chk("t2_lat4", lat, 17);
    chk("t2_avg", avg_out, 25);
    chk("t2_min", min_out, 10);
    chk("t2_max", max_out, 40);
    chk("t2_count", count, 4);

    // 3: 1..10 with duration 15 clamped to 8, buffer wraps
    do_reset();
    for (int i = 1; i <= 10; i++) send(8'(i), 4'd15, lat, rdy);
    chk("t3_lat", lat, 21);
    chk("t3_avg", avg_out, 6);
    chk("t3_min", min_out, 3);
    chk("t3_max", max_out, 10);
    chk("t3_count", count, 8);
    chk("t3_latest", latest_sample, 10);

    // 4: duration 0 gives zero results after one edge
    do_reset();
    send(8'd50, 4'd1, lat, rdy);
    chk("t4_pre_avg", avg_out, 50);
    send(8'd77, 4'd0, lat, rdy);
    chk("t4_lat", lat, 1);
    chk("t4_avg", avg_out, 0);
    chk("t4_min", min_out, 0);
    chk("t4_max", max_out, 0);
    chk("t4_latest", latest_sample, 77);
    chk("t4_count", count, 2);

    // 5: sample offered while busy is dropped; window 60,77,50
    @(negedge clock);
    sample = 8'd60;
    duration = 4'd8;
    sample_valid = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    @(posedge clock); #1;
    chk("t5_no_drop_e1", sample_dropped, 0);
    @(negedge clock);
    sample = 8'd99;
    duration = 4'd1;
    sample_valid = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    chk("t5_drop_pulse", sample_dropped, 1);
    chk("t5_drop_latest", latest_sample, 60);
    chk("t5_drop_count", count, 3);
    @(posedge clock); #1;
    chk("t5_drop_once", sample_dropped, 0);
    wait_avg(3, lat, rdy);
    chk("t5_lat", lat, 16);
    chk("t5_avg", avg_out, 62);
    chk("t5_min", min_out, 50);
    chk("t5_max", max_out, 77);
    chk("t5_latest", latest_sample, 60);
    chk("t5_count", count, 3);

    // 6: full-scale samples, then reset mid-divide
    do_reset();
    for (int i = 0; i < 8; i++) send(8'd255, 4'd8, lat, rdy);
    chk("t6_lat", lat, 21);
    chk("t6_avg", avg_out, 255);
    chk("t6_min", min_out, 255);
    chk("t6_max", max_out, 255);
    @(negedge clock);
    sample = 8'd255;
    duration = 4'd8;
    sample_valid = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    chk("t6_busy_ready", sample_ready, 0);
    reset = 1'b1;
    #1;
    chk("t6_abort_avg", avg_out, 0);
    chk("t6_abort_min", min_out, 0);
    chk("t6_abort_max", max_out, 0);
    chk("t6_abort_latest", latest_sample, 0);
    chk("t6_abort_count", count, 0);
    chk("t6_abort_valid", avg_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (avg_valid) seen = 1'b1;
    end
    chk("t6_no_valid_after_abort", seen, 0);
    send(8'd5, 4'd8, lat, rdy);
    chk("t6_post_lat", lat, 14);
    chk("t6_post_avg", avg_out, 5);
    chk("t6_post_min", min_out, 5);
    chk("t6_post_max", max_out, 5);
    chk("t6_post_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
